mdu_iter: RTL and testbench

//  Iterative multiply/divide unit for the EX stage. Executes MULT, MULTU, DIV and DIVU

---
 rtl/mdu_iter_pkg.sv | 27 ++
 rtl/mdu_iter_if.sv | 27 ++
 rtl/mdu_sign_fix.sv | 33 +++
 rtl/mdu_iter.sv | 129 ++++++++++++
 tb/tb_mdu_iter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes match the decoder's funct mapping.
package mdu_iter_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_SIGN = 2'b10,
        MDU_DONE = 2'b11
    } mdu_state_e;

    function automatic logic op_is_div(mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/result bundle between the EX stage and the MDU.
// master drives the request side, slave is the MDU itself.
interface mdu_iter_if #(
    parameter int WIDTH = 32
) ();
    import mdu_iter_pkg::*;

    logic             start;
    mdu_op_e          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_sign_fix.sv
// Combinational sign correction of the raw magnitude result.
// Divide-by-zero bypasses sign handling entirely.
module mdu_sign_fix import mdu_iter_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  mdu_op_e            i_op,
    input  logic               i_neg_q,
    input  logic               i_neg_r,
    input  logic               i_b0,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [2*WIDTH-1:0] i_raw,
    output logic [2*WIDTH-1:0] o_fix
);
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

    assign w_hi = i_raw[2*WIDTH-1:WIDTH];
    assign w_lo = i_raw[WIDTH-1:0];

    always_comb begin
        o_fix = i_raw;
        if (op_is_div(i_op)) begin
            if (i_b0) begin
                o_fix = {i_a, {WIDTH{1'b1}}};
            end else begin
                o_fix[2*WIDTH-1:WIDTH] = i_neg_r ? -w_hi : w_hi;
                o_fix[WIDTH-1:0]       = i_neg_q ? -w_lo : w_lo;
            end
        end else if (i_neg_q) begin
            o_fix = -i_raw;
        end
    end
endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit; WIDTH iterations plus sign and
// write-back cycles, result pair registered for the HILO file.
module mdu_iter import mdu_iter_pkg::*; #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input logic       clk,
    input logic       rst,
    mdu_iter_if.slave bus
);
    mdu_state_e         r_state;
    mdu_state_e         w_next;
    mdu_op_e            r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_m;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_b0;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_last;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_ma;
    logic [WIDTH-1:0]   w_mb;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_dshift;
    logic [WIDTH:0]     w_ddiff;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_fix;

    assign w_accept = bus.start & ~bus.flush;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_sa     = op_is_signed(bus.op) & bus.a[WIDTH-1];
    assign w_sb     = op_is_signed(bus.op) & bus.b[WIDTH-1];
    assign w_ma     = w_sa ? -bus.a : bus.a;
    assign w_mb     = w_sb ? -bus.b : bus.b;

    // MUL: acc = {partial, multiplier}; DIV: acc = {remainder, quotient}
    assign w_msum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_dshift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ddiff  = w_dshift - {1'b0, r_m};

    always_comb begin
        w_step = {w_msum, r_acc[WIDTH-1:1]};
        if (op_is_div(r_op)) begin
            if (w_ddiff[WIDTH])
                w_step = {w_dshift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            else
                w_step = {w_ddiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
    end

    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .i_op   (r_op),
        .i_neg_q(r_neg_q),
        .i_neg_r(r_neg_r),
        .i_b0   (r_b0),
        .i_a    (r_a),
        .i_raw  (r_acc),
        .o_fix  (w_fix)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= MDU_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            MDU_IDLE: if (w_accept) w_next = MDU_CALC;
            MDU_CALC: begin
                if (bus.flush)  w_next = MDU_IDLE;
                else if (w_last) w_next = MDU_SIGN;
            end
            MDU_SIGN: w_next = bus.flush ? MDU_IDLE : MDU_DONE;
            MDU_DONE: w_next = MDU_IDLE;
            default:  w_next = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= MDU_MULT;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_m     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_b0    <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= (r_state == MDU_DONE);
            if (r_state == MDU_IDLE && w_accept) begin
                r_op    <= bus.op;
                r_a     <= bus.a;
                r_cnt   <= '0;
                r_neg_q <= w_sa ^ w_sb;
                r_neg_r <= w_sa;
                r_b0    <= (bus.b == '0);
                r_m     <= op_is_div(bus.op) ? w_mb : w_ma;
                r_acc   <= {{WIDTH{1'b0}},
                            op_is_div(bus.op) ? w_ma : w_mb};
            end
            if (r_state == MDU_CALC) begin
                r_acc <= w_step;
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == MDU_SIGN) r_acc <= w_fix;
            // Written even if flush arrives now: DONE is past the cancel point
            if (r_state == MDU_DONE) {r_hi, r_lo} <= r_acc;
        end
    end

    assign bus.busy = (r_state != MDU_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed + scoreboard bench for mdu_iter (WIDTH=32).
// Results expected 34 edges after the accepting edge.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(W)) bus ();

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [2*W-1:0] exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(mdu_op_e op, logic [31:0] a,
                                          logic [31:0] b);
        longint sa;
        longint sbv;
        longint q;
        longint r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            MDU_MULT:  return sa * sbv;
            MDU_MULTU: return {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 0) return {a, 32'hffff_ffff};
                if (op == MDU_DIV) begin
                    q = sa / sbv;
                    r = sa % sbv;
                    return {r[31:0], q[31:0]};
                end
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic do_op(input string tag, input mdu_op_e op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
        int lat;
        int nbusy;
        int nchg;
        logic [63:0] prev;
        logic [63:0] e;
        exp_q.push_back(exp);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        prev  = {bus.hi, bus.lo};
        lat   = 0;
        nbusy = 0;
        nchg  = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) nbusy++;
            if ({bus.hi, bus.lo} !== prev) nchg++;
            tick();
            lat++;
        end
        chk({tag, ".lat"}, lat, 34);
        chk({tag, ".busy"}, nbusy, 34);
        chk({tag, ".hold"}, nchg, 0);
        e = exp_q.pop_front();
        chk({tag, ".hilo"}, {bus.hi, bus.lo}, e);
        tick();
        chk({tag, ".pulse"}, bus.done, 0);
    endtask

    initial begin
        int lat;
        int ndone;
        mdu_op_e op;
        logic [31:0] ra;
        logic [31:0] rb;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = MDU_MULT;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);
        chk("rst.hilo", {bus.hi, bus.lo}, 0);
        rst = 1'b0;

        do_op("multu", MDU_MULTU, 32'hffff_ffff, 32'h2,
              64'h0000_0001_ffff_fffe);
        do_op("mult", MDU_MULT, 32'hffff_fffd, 32'h7,
              64'hffff_ffff_ffff_ffeb);
        do_op("div", MDU_DIV, 32'hffff_fff9, 32'h2,
              64'hffff_ffff_ffff_fffd);
        do_op("divu", MDU_DIVU, 32'h7, 32'h2,
              64'h0000_0001_0000_0003);
        do_op("divu0", MDU_DIVU, 32'h64, 32'h0,
              64'h0000_0064_ffff_ffff);
        do_op("divovf", MDU_DIV, 32'h8000_0000, 32'hffff_ffff,
              64'h0000_0000_8000_0000);
        do_op("div0s", MDU_DIV, 32'hffff_fff9, 32'h0,
              64'hffff_fff9_ffff_ffff);
        do_op("multmin", MDU_MULT, 32'h8000_0000, 32'h8000_0000,
              64'h4000_0000_0000_0000);
        do_op("divneg", MDU_DIV, 32'h0000_0007, 32'hffff_fffe,
              64'h0000_0001_ffff_fffd);

        for (int i = 0; i < 8; i++) begin
            op = mdu_op_e'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 1) ? $urandom
                                             : $urandom_range(0, 15);
            do_op("rand", op, ra, rb, model(op, ra, rb));
        end

        // Flush mid-DIV leaves the preloaded hi/lo intact
        do_op("preload", MDU_MULTU, 32'h8000_0001, 32'h2,
              64'h0000_0001_0000_0002);
        bus.op    = MDU_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush.busy", bus.busy, 0);
        chk("flush.done", bus.done, 0);
        chk("flush.hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0002);
        do_op("postflush", MDU_DIVU, 32'd100, 32'd7,
              64'h0000_0002_0000_000e);

        // Second start while busy is ignored
        bus.op    = MDU_MULTU;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.op    = MDU_DIV;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 5;
        while (bus.done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        chk("ign.lat", lat, 34);
        chk("ign.hilo", {bus.hi, bus.lo}, 64'd15);
        ndone = 0;
        repeat (40) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        chk("ign.ndone", ndone, 0);

        // start+flush together in IDLE: nothing starts
        bus.op    = MDU_MULTU;
        bus.a     = 32'd6;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("sf.busy", bus.busy, 0);
        ndone = 0;
        repeat (40) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        chk("sf.ndone", ndone, 0);
        chk("sf.hilo", {bus.hi, bus.lo}, 64'd15);

        // Reset in the middle of CALC
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        chk("midrst.pre", bus.busy, 1);
        rst = 1'b1;
        tick();
        chk("midrst.busy", bus.busy, 0);
        chk("midrst.done", bus.done, 0);
        chk("midrst.hilo", {bus.hi, bus.lo}, 0);
        rst = 1'b0;
        do_op("recover", MDU_MULT, 32'hffff_ffff, 32'hffff_ffff,
              64'h0000_0000_0000_0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
